// File: rtl/lbr_pkg.sv
// lbr_pkg: shared LBR encodings for the drain controller and LBR_unit
package lbr_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_TOS  = 3'd1;
  localparam logic [2:0] S_RD_FROM = 3'd2;
  localparam logic [2:0] S_RD_TO   = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;
  localparam logic [1:0] FROM_BANK = 2'b00;
  localparam logic [1:0] TO_BANK   = 2'b01;
  function automatic int sel_w(input int lbr_size);
    return $clog2(lbr_size) + 2;
  endfunction
  function automatic int tos_addr(input int lbr_size);
    return 1 << (sel_w(lbr_size) - 1);
  endfunction
endpackage

// File: rtl/lbr_drain_ctrl.sv
// lbr_drain_ctrl: freezes the LBR, walks entries newest-to-oldest onto a record stream, optionally clears TOS
module lbr_drain_ctrl
  import lbr_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LBR_SIZE    = 16,
  parameter int DRAIN_DEPTH = 16,
  localparam int SEL_W      = sel_w(LBR_SIZE),
  localparam int IW         = $clog2(LBR_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_after,
  input  logic                  cpu_busy,
  output logic                  rd_en,
  output logic [SEL_W-1:0]      rd_sel,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [SEL_W-1:0]      wr_sel,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  freeze,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [DATA_WIDTH-1:0] rec_from,
  output logic [DATA_WIDTH-1:0] rec_to,
  output logic [IW-1:0]         rec_idx,
  output logic                  rec_last,
  output logic                  busy,
  output logic                  done
);
  localparam logic [SEL_W-1:0] TOS_ADDR = SEL_W'(tos_addr(LBR_SIZE));
  logic [2:0] state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, ptr_q, ptr_d, idx;
  logic [DATA_WIDTH-1:0] from_q, from_d, to_q, to_d;
  logic clear_q, clear_d, freeze_q, freeze_d, last;
  assign idx = ptr_q - cnt_q;
  assign last = cnt_q == IW'(DRAIN_DEPTH - 1);
  always_comb begin
    rd_en = !cpu_busy && (state_q == S_RD_TOS || state_q == S_RD_FROM || state_q == S_RD_TO);
    rd_sel = state_q == S_RD_TOS  ? TOS_ADDR :
             state_q == S_RD_FROM ? {FROM_BANK, idx} :
             state_q == S_RD_TO   ? {TO_BANK, idx} : '0;
    wr_en = !cpu_busy && state_q == S_CLEAR;
    wr_sel = wr_en ? TOS_ADDR : '0;
    wr_data = '0;
    freeze = freeze_q;
    rec_valid = state_q == S_EMIT;
    rec_from = from_q;
    rec_to = to_q;
    rec_idx = idx;
    rec_last = rec_valid && last;
    busy = state_q != S_IDLE;
    done = state_q == S_FIN;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    from_d = from_q;
    to_d = to_q;
    clear_d = clear_q;
    freeze_d = freeze_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD_TOS;
        clear_d = clear_after;
        cnt_d = '0;
        freeze_d = 1'b1;
      end
      S_RD_TOS: if (rd_en) begin
        ptr_d = rd_data[IW-1:0];
        state_d = S_RD_FROM;
      end
      S_RD_FROM: if (rd_en) begin
        from_d = rd_data;
        state_d = S_RD_TO;
      end
      S_RD_TO: if (rd_en) begin
        to_d = rd_data;
        state_d = S_EMIT;
      end
      S_EMIT: if (rec_ready) begin
        cnt_d = cnt_q + 1'b1;
        state_d = last ? (clear_q ? S_CLEAR : S_FIN) : S_RD_FROM;
      end
      S_CLEAR: state_d = wr_en ? S_FIN : S_CLEAR;
      S_FIN: begin
        freeze_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      from_q <= '0;
      to_q <= '0;
      clear_q <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      from_q <= from_d;
      to_q <= to_d;
      clear_q <= clear_d;
      freeze_q <= freeze_d;
    end
  end
endmodule
